// File: rtl/rv32_mdu_seq.sv
// rv32_mdu_seq: iterative RV32M multiply/divide unit; define MDU_EARLY_OUT_EN to finish trivial cases in one cycle
module rv32_mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] prod;
  logic              a_sgn, b_sgn, early;
  logic [XLEN-1:0]   a_mag, b_mag, rem_fix, fix_res, early_res;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  // operand magnitudes, one iteration step of each algorithm, sign fix-up and early-out detection
  always_comb begin
    a_sgn     = opA[XLEN-1] & (op == 3'b001 || op == 3'b010 || op == 3'b100 || op == 3'b110);
    b_sgn     = opB[XLEN-1] & (op == 3'b001 || op == 3'b100 || op == 3'b110);
    a_mag     = a_sgn ? -opA : opA;
    b_mag     = b_sgn ? -opB : opB;
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    div_diff  = prod[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    prod_fix  = (a_neg ^ b_neg) ? -prod : prod;
    rem_fix   = a_neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    fix_res   = !op_q[2] ? (op_q[1:0] == 2'b00 ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN])
              : op_q[1] ? rem_fix : (opnd == '0 ? '1 : prod_fix[XLEN-1:0]);
    early     = EARLY_OUT && (op[2] ? (opB == '0 || (!op[0] && opA == {1'b1, {(XLEN-1){1'b0}}} && opB == '1))
                                    : (opA == '0 || opB == '0));
    early_res = !op[2] ? '0 : opB == '0 ? (op[1] ? opA : '1) : (op[1] ? '0 : opA);
  end
  // sequencing FSM with shared product/remainder-quotient register and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      op_q   <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
    end else begin
      done <= 1'b0;
      if (kill && state != IDLE) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else
        case (state)
          IDLE: if (start && !kill) begin
            op_q  <= op;
            a_neg <= a_sgn;
            b_neg <= b_sgn;
            cnt   <= '0;
            opnd  <= op[2] ? b_mag : a_mag;
            prod  <= {{XLEN{1'b0}}, op[2] ? a_mag : b_mag};
            busy  <= 1'b1;
            if (early) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= early_res;
            end else
              state <= CALC;
          end
          CALC: begin
            cnt  <= cnt + 1'b1;
            prod <= !op_q[2] ? {mul_sum, prod[XLEN-1:1]}
                  : div_diff[XLEN] ? {prod[2*XLEN-2:0], 1'b0}
                  : {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
            if (cnt == CNT_W'(XLEN-1)) state <= FIX;
          end
          FIX: begin
            state  <= DONE;
            done   <= 1'b1;
            result <= fix_res;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
    end
endmodule

// File: tb/tb_rv32_mdu_seq.sv
// tb_rv32_mdu_seq: directed vector bench for rv32_mdu_seq
module tb_rv32_mdu_seq;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n, start, kill, busy, done;
  logic [2:0]  op;
  logic [31:0] opA, opB, result;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          triv;
  } vec_t;
  vec_t vecs[$];
  rv32_mdu_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .kill(kill), .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op  = 3'($urandom_range(7, 0));
    opA = $urandom;
    opB = $urandom;
  endtask
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 1;
    bcnt = int'(busy);
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      bcnt += int'(busy);
    end
  endtask
  initial begin
    int lat, bcnt, el;
    logic [31:0] last_exp;
    rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = '0; opA = '0; opB = '0;
    vecs.push_back('{3'b000, 32'd7,         32'd6,         32'd42,        1'b0});
    vecs.push_back('{3'b001, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF,  1'b0});
    vecs.push_back('{3'b011, 32'hFFFFFFFF,  32'd2,         32'h00000001,  1'b0});
    vecs.push_back('{3'b100, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  1'b0});
    vecs.push_back('{3'b110, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  1'b0});
    vecs.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1});
    vecs.push_back('{3'b111, 32'd5,         32'd0,         32'd5,         1'b1});
    vecs.push_back('{3'b100, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  1'b1});
    vecs.push_back('{3'b110, 32'h80000000,  32'hFFFFFFFF,  32'h00000000,  1'b1});
    vecs.push_back('{3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0});
    vecs.push_back('{3'b000, 32'hFFFFFFFD,  32'd5,         32'hFFFFFFF1,  1'b0});
    vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        1'b0});
    vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         1'b0});
    vecs.push_back('{3'b100, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  1'b0});
    vecs.push_back('{3'b110, 32'd7,         32'hFFFFFFFE,  32'd1,         1'b0});
    vecs.push_back('{3'b100, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  1'b1});
    vecs.push_back('{3'b110, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFB,  1'b1});
    vecs.push_back('{3'b000, 32'd0,         32'd5,         32'd0,         1'b1});
    vecs.push_back('{3'b001, 32'h80000000,  32'h80000000,  32'h40000000,  1'b0});
    vecs.push_back('{3'b011, 32'h80000000,  32'h80000000,  32'h40000000,  1'b0});
    vecs.push_back('{3'b001, 32'h80000000,  32'h7FFFFFFF,  32'hC0000000,  1'b0});
    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      el = (EARLY && vecs[i].triv) ? 1 : 34;
      chk($sformatf("v%0d result", i), result, vecs[i].exp);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(el));
      chk($sformatf("v%0d busy cycles", i), 32'(bcnt), 32'(el));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d idle after done", i), {30'b0, busy, done}, 32'd0);
    end
    last_exp = vecs[vecs.size()-1].exp;
    issue(3'b100, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill busy", 32'(busy), 32'd0);
    chk("kill done", 32'(done), 32'd0);
    chk("kill result kept", result, last_exp);
    issue(3'b000, 32'd3, 32'd3);
    wait_done(lat, bcnt);
    chk("after kill result", result, 32'd9);
    chk("after kill latency", 32'(lat), 32'd34);
    @(negedge clk);
    start = 1'b1; kill = 1'b1; op = 3'b000; opA = 32'd4; opB = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    chk("start with kill ignored", 32'(busy), 32'd0);
    issue(3'b000, 32'd7, 32'd6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b101; opA = 32'd1000; opB = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat, bcnt);
    chk("start in calc done", 32'(done), 32'd1);
    chk("start in calc result", result, 32'd42);
    @(posedge clk);
    #1;
    chk("start in calc no restart", 32'(busy), 32'd0);
    issue(3'b001, 32'd5, 32'd5);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset done", 32'(done), 32'd0);
    chk("mid reset result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b000, 32'd3, 32'd3);
    wait_done(lat, bcnt);
    chk("post reset result", result, 32'd9);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32_mdu_seq.md
Name: rv32_mdu_seq

Overview:
- Iterative RV32M multiply/divide unit with its sequencing FSM, placed in the execute stage beside the single-cycle ALU.
- Accepts one operation at a time from ID/EX operands.
- Drives busy into the ID/EX busy input and the upstream stall path.
- Returns a 32-bit result with a one-cycle done pulse, so EX/MEM captures it at completion.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
opA  in  XLEN  rs1 operand (forwarded value)
opB  in  XLEN  rs2 operand (forwarded value)
kill  in  1  pipeline flush; aborts the operation in flight
busy  out  1  operation in flight; stall request
done  out  1  one-cycle pulse, result valid
result  out  XLEN  final result, held until the next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIX, DONE. Encoding is free.
- IDLE:
  - start=1 and kill=0 → latch op, |opA|, |opB| and the sign flags; counter=0; go to CALC.
  - kill=1 in the same cycle as start: start is ignored.
- CALC: one iteration per cycle for exactly XLEN cycles. counter increments every cycle; when counter==XLEN-1, go to FIX.
  - MUL*: shift-add on the 64-bit product register using unsigned magnitudes.
  - DIV*/REM*: restoring division with a 32-bit remainder and quotient.
- FIX: apply sign correction, select the result, go to DONE.
  - MULH: product negated if the signs differ; upper word taken.
  - MULHSU: only opA's sign counts.
  - MULHU: no sign correction.
  - MUL: lower word.
  - DIV: quotient negated if the signs differ.
  - REM: remainder takes the dividend's sign.
- DONE: done=1 for one cycle; result register updated on entry. Next state is IDLE.
- busy = (state != IDLE), registered. It is 0 in the cycle start is sampled and 1 from the next cycle through the DONE cycle inclusive.
- The fetch/decode path must hold the issuing instruction in EX until done. Total latency: start sample edge → done high 34 cycles later (32 CALC + FIX + DONE).
- start while busy=1 is ignored. No queueing, no error flag.
- kill=1 in CALC, FIX or DONE → next state IDLE, no done pulse, result keeps its previous value.
- kill has priority over every other transition. kill in the DONE cycle itself still suppresses nothing: done is already high and result is already updated.
- Divide by zero (opB=0):
  - DIV/DIVU quotient = 0xFFFFFFFF.
  - REM/REMU remainder = opA.
  - Handled by the normal algorithm plus FIX selection. No exception.
- Signed overflow (opA=0x80000000, opB=0xFFFFFFFF):
  - DIV = 0x80000000.
  - REM = 0.
- Operands are captured at start. Later changes of opA/opB/op during CALC have no effect.
- Arithmetic is modulo 2^XLEN on all outputs. Product register is 2*XLEN wide internally.

Optional Feature:
MDU_EARLY_OUT_EN:
- Defined: in IDLE with start=1, any of the following skips CALC and FIX and goes directly to DONE, so done is high 1 cycle after the sample edge:
  - opB==0 on a divide/remainder op;
  - signed overflow on DIV/REM;
  - opA==0 or opB==0 on any MUL* op.
- The result equals the architected value for that case. busy is 1 only in that DONE cycle.
- Not defined: every operation takes the full 34-cycle latency. Results are identical.

Test Plan:
- MUL, opA=7, opB=6 → done 34 cycles after start, result=42, busy high exactly 34 cycles.
- MULH, opA=0xFFFFFFFF (-1), opB=2; then MULHU with the same operands → result=0xFFFFFFFF, then 0x00000001.
- DIV, opA=-7 (0xFFFFFFF9), opB=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- DIVU, opA=5, opB=0 → 0xFFFFFFFF. REMU with the same operands → 5. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - With MDU_EARLY_OUT_EN defined: done 1 cycle after start for all three.
- Issue DIV, assert kill at CALC cycle 10 → IDLE next cycle, no done, result unchanged. A new MUL 3×3 issued 1 cycle later → 9.
- Assert start during CALC with different operands → ignored; the first op's result is returned. Assert rst_n=0 mid-CALC → busy, done and result are 0 immediately.
